count_timer: RTL
================

// Module: count_timer
// PURPOSE
//  Parametrised BCD MM:SS stopwatch/countdown timer. Runs entirely on one clock
//  and uses clock-enable ticks instead of a muxed clock. Adds up/down counting,
//  preset load, expiry/wrap flags and a lap-hold display freeze.
//  Sits between the tick divider and the 7-segment display driver.
// PARAMETERS
//  MIN_MAX    59  highest minute value shown (1..99); the count wraps/expires past MIN_MAX:59
//  DOWN_WRAP  0   1: a down-count at 00:00 wraps to MIN_MAX:59; 0: it holds and sets expired
// PORTS
//  clk         in   1  system clock; all state updates on posedge
//  reset       in   1  synchronous, active-low
//  tick        in   1  1 Hz count enable, one clk wide
//  tick_adj    in   1  adjust-rate enable (e.g. 2 Hz), one clk wide
//  pause       in   1  level (debounced upstream); each rising edge toggles paused
//  adjust      in   1  level; 1 = adjust mode
//  select      in   1  adjust field: 1 = seconds, 0 = minutes
//  dir         in   1  0 = count up, 1 = count down
//  load        in   1  one-cycle pulse; loads the preset
//  preset_min  in   8  BCD {tens,units}
//  preset_sec  in   8  BCD {tens,units}
//  lap         in   1  level; each rising edge toggles lap hold
//  min1,min0   out  4  displayed minute tens/units, BCD
//  sec1,sec0   out  4  displayed second tens/units, BCD
//  paused      out  1  current pause state
//  expired     out  1  sticky; the countdown reached 00:00 (DOWN_WRAP=0 only)
//  wrap        out  1  one-clk pulse when the count wraps in either direction
// BEHAVIOUR
//  - Reset (reset==0 at posedge): count = 00:00, all outputs 0, paused=0, lap_hold=0.
//    The pause/lap edge-detect registers reset to 1, so a level held through reset
//    does not cause a toggle.
//  - Edge detect: rise = in & ~in_q. A rise changes state on the same posedge;
//    the output is visible one cycle later.
//  - Per-cycle priority: reset > load > adjust > count.
//  - load: count <= preset, expired <= 0, lap_hold <= 0.
//    - Out-of-range presets are clamped per field: any digit >9, seconds >59 or
//      minutes >MIN_MAX load the field maximum (59 / MIN_MAX).
//  - adjust==1:
//    - tick is ignored and the time does not advance.
//    - On tick_adj, the selected field increments modulo its range (0..59 or
//      0..MIN_MAX) with no carry into the other field.
//    - paused does not block adjust. Each adjust step clears expired.
//  - Counting:
//    - Applies when adjust==0 && ~paused && tick. Each tick moves the count
//      +/-1 s with full BCD carry/borrow (s0 9->0, s1 5->0, m0 9->0, m1 up to MIN_MAX).
//    - Up count at MIN_MAX:59 goes to 00:00 and pulses wrap.
//    - Down count from 00:01 to 00:00 sets expired on that same posedge.
//    - Down count at 00:00:
//      - DOWN_WRAP=0: the count holds and expired stays 1.
//      - DOWN_WRAP=1: the count goes to MIN_MAX:59 and pulses wrap; expired is never set.
//  - Lap hold:
//    - On a lap rise, a snapshot of the count is captured and the display outputs
//      show it while the internal count keeps running. The next rise releases the hold.
//    - Reset or load clears the hold. Outputs are registered with 1 clk latency from tick.
//  - dir may change at any time and takes effect on the next tick.
//    A pause rise coinciding with tick: the tick is still applied, using the old
//    paused value.
//  - Internal time is held as BCD digit registers; no binary conversion.
// TESTING
//  1. Reset, then 60 ticks up -> 01:00; 0 wrap pulses.
//  2. MIN_MAX=59 preset 59:58, dir=0, 2 ticks -> 00:00 with a single wrap pulse on the 2nd tick.
//  3. Preset 00:02, dir=1, 3 ticks, DOWN_WRAP=0 -> 00:01, 00:00 with expired=1, then
//     still 00:00; load clears expired.
//  4. Preset 00:59 with adjust=1, select=1, 1 tick_adj -> 00:00 and minutes unchanged;
//     concurrent tick has no effect.
//  5. Pause rise, 5 ticks -> count frozen; second pause rise, 1 tick -> +1 s.
//     pause held through reset -> paused=0.
//  6. Lap rise at 00:10, 5 ticks -> display 00:10; lap rise -> display 00:15.
//     Preset 7A:99 load -> 59:59.

Source files
------------

// File: rtl/count_timer.sv
// BCD MM:SS stopwatch / countdown timer driven by clock-enable ticks.
// Supports up/down counting, clamped preset load, field adjust, pause, and lap-hold display freeze.
module count_timer #(
  parameter int MIN_MAX   = 59,
  parameter bit DOWN_WRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       tick_adj,
  input  logic       pause,
  input  logic       adjust,
  input  logic       select,
  input  logic       dir,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  input  logic       lap,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic       paused,
  output logic       expired,
  output logic       wrap
);

  localparam logic [7:0] MAX_MIN = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
  localparam logic [7:0] MAX_SEC = 8'h59;

  // Count and snapshot are packed as {m1, m0, s1, s0} BCD digits.
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] snap_q, snap_d;
  logic [15:0] disp_q, disp_d;
  logic        paused_q, paused_d;
  logic        lapHold_q, lapHold_d;
  logic        expired_q, expired_d;
  logic        wrap_q, wrap_d;
  logic        pausePrev_q, lapPrev_q;
  logic        pauseRise, lapRise;

  // Out-of-range fields (bad digit or value above the field maximum) saturate.
  function automatic logic [7:0] clampField(input logic [7:0] v, input int maxVal);
    int value;
    value = int'(v[7:4]) * 10 + int'(v[3:0]);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || value > maxVal)
      return {4'(maxVal / 10), 4'(maxVal % 10)};
    return v;
  endfunction

  function automatic logic [7:0] incField(input logic [7:0] v, input logic [7:0] maxV);
    if (v == maxV)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] decField(input logic [7:0] v, input logic [7:0] maxV);
    if (v == 8'h00)
      return maxV;
    if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign pauseRise = pause & ~pausePrev_q;
  assign lapRise   = lap & ~lapPrev_q;

  always_comb begin
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    paused_d  = paused_q ^ pauseRise;
    lapHold_d = lapHold_q;
    expired_d = expired_q;
    wrap_d    = 1'b0;

    if (lapRise) begin
      lapHold_d = ~lapHold_q;
      if (!lapHold_q)
        snap_d = cnt_q;
    end

    if (load) begin
      cnt_d     = {clampField(preset_min, MIN_MAX), clampField(preset_sec, 59)};
      expired_d = 1'b0;
      lapHold_d = 1'b0;
    end else if (adjust) begin
      if (tick_adj) begin
        if (select)
          cnt_d[7:0] = incField(cnt_q[7:0], MAX_SEC);
        else
          cnt_d[15:8] = incField(cnt_q[15:8], MAX_MIN);
        expired_d = 1'b0;
      end
    end else if (!paused_q && tick) begin
      // The old paused value gates this tick even if a pause rise lands now.
      if (!dir) begin
        if (cnt_q == {MAX_MIN, MAX_SEC}) begin
          cnt_d  = 16'h0000;
          wrap_d = 1'b1;
        end else begin
          cnt_d[7:0] = incField(cnt_q[7:0], MAX_SEC);
          if (cnt_q[7:0] == MAX_SEC)
            cnt_d[15:8] = incField(cnt_q[15:8], MAX_MIN);
        end
      end else begin
        if (cnt_q == 16'h0000) begin
          if (DOWN_WRAP) begin
            cnt_d  = {MAX_MIN, MAX_SEC};
            wrap_d = 1'b1;
          end else begin
            expired_d = 1'b1;
          end
        end else begin
          cnt_d[7:0] = decField(cnt_q[7:0], MAX_SEC);
          if (cnt_q[7:0] == 8'h00)
            cnt_d[15:8] = decField(cnt_q[15:8], MAX_MIN);
          if (!DOWN_WRAP && cnt_q == 16'h0001)
            expired_d = 1'b1;
        end
      end
    end

    disp_d = lapHold_d ? snap_d : cnt_d;
  end

  // Edge-detect history resets high so levels held through reset never toggle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= 16'h0000;
      snap_q      <= 16'h0000;
      disp_q      <= 16'h0000;
      paused_q    <= 1'b0;
      lapHold_q   <= 1'b0;
      expired_q   <= 1'b0;
      wrap_q      <= 1'b0;
      pausePrev_q <= 1'b1;
      lapPrev_q   <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      disp_q      <= disp_d;
      paused_q    <= paused_d;
      lapHold_q   <= lapHold_d;
      expired_q   <= expired_d;
      wrap_q      <= wrap_d;
      pausePrev_q <= pause;
      lapPrev_q   <= lap;
    end
  end

  assign {min1, min0, sec1, sec0} = disp_q;
  assign paused  = paused_q;
  assign expired = expired_q;
  assign wrap    = wrap_q;

endmodule
